dbg_run_ctrl: RTL

DBG_RUN_CTRL -- requirements
Module: dbg_run_ctrl

---
 rtl/dbg_pkg.sv | 23 ++
 rtl/dbg_brk_match.sv | 65 ++++++
 rtl/dbg_run_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared encodings for the debug run controller: run states, stop causes and
// the breakpoint-index width rule.
package dbg_pkg;

   typedef enum logic [1:0] {
      ST_PAUSE = 2'd0,
      ST_STEP  = 2'd1,
      ST_CONT  = 2'd2
   } run_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE      = 2'd0,
      CAUSE_STEP_DONE = 2'd1,
      CAUSE_BRK       = 2'd2,
      CAUSE_HALT      = 2'd3
   } halt_cause_e;

   // A single breakpoint slot still needs a one-bit index port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dbg_brk_match.sv
// Hardware breakpoint slots: address/enable storage plus the PC comparator
// array and lowest-index priority encoder.
module dbg_brk_match
   import dbg_pkg::*;
#(
   parameter int AW      = 32,
   parameter int NUM_BRK = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         wr_en,
   input  logic [idx_w(NUM_BRK)-1:0]    wr_idx,
   input  logic [AW-1:0]                wr_addr,
   input  logic                         wr_slot_en,
   input  logic                         armed,
   input  logic [AW-1:0]                pc,
   output logic                         match,
   output logic [idx_w(NUM_BRK)-1:0]    match_idx
);

   localparam int IW = idx_w(NUM_BRK);

   logic [AW-1:0]      addr_q [NUM_BRK];
   logic [AW-1:0]      addr_d [NUM_BRK];
   logic [NUM_BRK-1:0] en_q;
   logic [NUM_BRK-1:0] en_d;
   logic [NUM_BRK-1:0] hit_s;

   // Slot write; indices beyond the implemented slots are dropped.
   always_comb begin
      addr_d = addr_q;
      en_d   = en_q;
      if (wr_en && (32'(wr_idx) < 32'(NUM_BRK))) begin
         addr_d[wr_idx] = wr_addr;
         en_d[wr_idx]   = wr_slot_en;
      end else begin
         en_d = en_q;
      end
   end

   // Slot storage; addresses park at all-ones so a cleared slot never aliases PC 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_BRK; i++) begin
            addr_q[i] <= {AW{1'b1}};
         end
         en_q <= {NUM_BRK{1'b0}};
      end else begin
         addr_q <= addr_d;
         en_q   <= en_d;
      end
   end

   // Comparators and priority encoder: scanning downward leaves the lowest hit.
   always_comb begin
      hit_s     = {NUM_BRK{1'b0}};
      match_idx = {IW{1'b0}};
      for (int i = NUM_BRK - 1; i >= 0; i--) begin
         hit_s[i]  = armed & en_q[i] & (addr_q[i] == pc);
         match_idx = hit_s[i] ? IW'(i) : match_idx;
      end
      match = |hit_s;
   end

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run controller: gates the CPU clock enable for N-instruction steps and
// free-run, stopping on halt, step completion or a hardware breakpoint.
module dbg_run_ctrl
   import dbg_pkg::*;
#(
   parameter int AW      = 32,
   parameter int NUM_BRK = 4,
   parameter int CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         step,
   input  logic                         cont,
   input  logic                         halt,
   input  logic [CNT_W-1:0]             step_n,
   input  logic                         brk_we,
   input  logic [idx_w(NUM_BRK)-1:0]    brk_idx,
   input  logic [AW-1:0]                brk_addr,
   input  logic                         brk_en,
   input  logic                         clr_cnt,
   input  logic [AW-1:0]                pc,
   output logic                         cpu_en,
   output logic [1:0]                   state,
   output logic [1:0]                   halt_cause,
   output logic [idx_w(NUM_BRK)-1:0]    brk_hit_idx,
   output logic [31:0]                  run_cycles
);

   localparam int IW = idx_w(NUM_BRK);

   run_state_e       state_q, state_d;
   halt_cause_e      cause_q, cause_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             armed_q, armed_d;
   logic [IW-1:0]    hit_idx_q, hit_idx_d;
   logic [31:0]      run_cycles_q, run_cycles_d;

   logic             running_s;
   logic             brk_match_s;
   logic [IW-1:0]    brk_idx_s;
   logic             cpu_en_s;
   logic [CNT_W-1:0] step_load_s;

   assign running_s   = (state_q != ST_PAUSE);
   // Derived from state_q so an asynchronous reset drops the enable at once.
   assign cpu_en_s    = running_s & ~halt & ~brk_match_s;
   assign step_load_s = (step_n == {CNT_W{1'b0}}) ? CNT_W'(1'b1) : step_n;

   dbg_brk_match #(
      .AW      (AW),
      .NUM_BRK (NUM_BRK)
   ) u_brk (
      .clk        (clk),
      .rstn       (rstn),
      .wr_en      (brk_we & ~running_s),
      .wr_idx     (brk_idx),
      .wr_addr    (brk_addr),
      .wr_slot_en (brk_en),
      .armed      (armed_q),
      .pc         (pc),
      .match      (brk_match_s),
      .match_idx  (brk_idx_s)
   );

   // Run-state transitions and stop-cause capture.
   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      cause_d   = cause_q;
      hit_idx_d = hit_idx_q;
      armed_d   = running_s;
      case (state_q)
         ST_PAUSE: begin
            if (halt) begin
               state_d = ST_PAUSE;
            end else if (step) begin
               state_d  = ST_STEP;
               remain_d = step_load_s;
            end else if (cont) begin
               state_d = ST_CONT;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_STEP, ST_CONT: begin
            if (halt) begin
               state_d = ST_PAUSE;
               cause_d = CAUSE_HALT;
            end else if (brk_match_s) begin
               state_d   = ST_PAUSE;
               cause_d   = CAUSE_BRK;
               hit_idx_d = brk_idx_s;
            end else if (state_q == ST_CONT) begin
               state_d = ST_CONT;
            end else if (remain_q == CNT_W'(1'b1)) begin
               state_d  = ST_PAUSE;
               cause_d  = CAUSE_STEP_DONE;
               remain_d = {CNT_W{1'b0}};
            end else if (cont) begin
               state_d  = ST_CONT;
               remain_d = {CNT_W{1'b0}};
            end else begin
               remain_d = remain_q - CNT_W'(1'b1);
            end
         end
         default: begin
            state_d = ST_PAUSE;
         end
      endcase
   end

   // Saturating retire counter; clear beats increment.
   always_comb begin
      if (clr_cnt) begin
         run_cycles_d = 32'd0;
      end else if (cpu_en_s && (run_cycles_q != 32'hFFFF_FFFF)) begin
         run_cycles_d = run_cycles_q + 32'd1;
      end else begin
         run_cycles_d = run_cycles_q;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_PAUSE;
         cause_q      <= CAUSE_NONE;
         remain_q     <= {CNT_W{1'b0}};
         armed_q      <= 1'b0;
         hit_idx_q    <= {IW{1'b0}};
         run_cycles_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         remain_q     <= remain_d;
         armed_q      <= armed_d;
         hit_idx_q    <= hit_idx_d;
         run_cycles_q <= run_cycles_d;
      end
   end

   assign cpu_en      = cpu_en_s;
   assign state       = state_q;
   assign halt_cause  = cause_q;
   assign brk_hit_idx = hit_idx_q;
   assign run_cycles  = run_cycles_q;

endmodule
